// File: rtl/ifid_stage.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the fetched instruction and PC+4, detects load-use hazards, and
// runs the interrupt-entry sequencer that drains the pipeline and records
// the exception PC.
// Build option: define IFID_LOADUSE_EN to enable load-use hazard detection;
// without it the hazard term is tied low and software schedules delay slots.
module ifid_stage #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instructionIF,
    input  logic [31:0] PCplus4IF,
    input  logic        PCSrcMEM,
    input  logic [31:0] branchaddrMEM,
    input  logic        MemReadEX,
    input  logic [4:0]  rtEX,
    input  logic        intterupt,
    output logic [31:0] instructionID,
    output logic [31:0] PCplus4ID,
    output logic        validID,
    output logic        stall,
    output logic        flushEX,
    output logic        intrTaken,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TAKE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] epc_q;
    logic        intrTaken_q;
    logic        pending_q;
    logic        intrPrev_q;
    logic [2:0]  drainCnt_q;
    logic        loadUse;
    logic        intrEdge;

`ifdef IFID_LOADUSE_EN
    // A load in EX whose destination feeds either source of the ID instruction
    assign loadUse = MemReadEX & valid_q & (rtEX != 5'd0) &
                     ((rtEX == instr_q[25:21]) | (rtEX == instr_q[20:16]));
`else
    logic unusedLoadUse;
    assign loadUse       = 1'b0;
    assign unusedLoadUse = ^{MemReadEX, rtEX};
`endif

    assign intrEdge = intterupt & ~intrPrev_q;

    // A taken branch suppresses the stall since the held instruction is squashed anyway
    assign stall   = (loadUse & ~PCSrcMEM) | (state_q == DRAIN);
    assign flushEX = PCSrcMEM | loadUse | (state_q != RUN);

    assign instructionID = instr_q;
    assign PCplus4ID     = pc4_q;
    assign validID       = valid_q;
    assign epc           = epc_q;
    assign intrTaken     = intrTaken_q;

    // Next IF/ID contents: squash on branch or interrupt entry, hold on load-use
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (PCSrcMEM || (state_q != RUN)) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!loadUse) begin
            instr_d = instructionIF;
            pc4_d   = PCplus4IF;
            valid_d = 1'b1;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Interrupt-entry sequencer: edge detect, deferral, drain countdown and take pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            drainCnt_q  <= 3'd0;
            epc_q       <= 32'h0;
            intrTaken_q <= 1'b0;
            intrPrev_q  <= 1'b0;
        end else begin
            intrPrev_q  <= intterupt;
            intrTaken_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if ((intrEdge || pending_q) && !PCSrcMEM) begin
                        state_q    <= DRAIN;
                        pending_q  <= 1'b0;
                        drainCnt_q <= 3'(DRAIN_CYCLES - 1);
                        epc_q      <= valid_q ? (pc4_q - 32'd4) : (PCplus4IF - 32'd4);
                    end else if (intrEdge) begin
                        pending_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (intrEdge) begin
                        pending_q <= 1'b1;
                    end
                    if (PCSrcMEM) begin
                        epc_q <= branchaddrMEM;
                    end
                    if (drainCnt_q == 3'd0) begin
                        state_q     <= TAKE;
                        intrTaken_q <= 1'b1;
                    end else begin
                        drainCnt_q <= drainCnt_q - 3'd1;
                    end
                end
                TAKE: begin
                    if (intrEdge) begin
                        pending_q <= 1'b1;
                    end
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifid_stage.sv
// Self-checking bench for ifid_stage: fetch path, load-use hazard,
// branch squash and the interrupt-entry sequence.
module tb_ifid_stage;

    localparam int DRAIN_CYCLES = 3;
`ifdef IFID_LOADUSE_EN
    localparam logic LU_EN = 1'b1;
`else
    localparam logic LU_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        chkPc;
    } idExp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instructionIF;
    logic [31:0] PCplus4IF;
    logic        PCSrcMEM;
    logic [31:0] branchaddrMEM;
    logic        MemReadEX;
    logic [4:0]  rtEX;
    logic        intterupt;
    logic [31:0] instructionID;
    logic [31:0] PCplus4ID;
    logic        validID;
    logic        stall;
    logic        flushEX;
    logic        intrTaken;
    logic [31:0] epc;

    idExp_t      idQueue[$];
    logic [31:0] epcQueue[$];
    int          assertCount = 0;
    int          failCount   = 0;

    ifid_stage #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk),
        .reset(reset),
        .instructionIF(instructionIF),
        .PCplus4IF(PCplus4IF),
        .PCSrcMEM(PCSrcMEM),
        .branchaddrMEM(branchaddrMEM),
        .MemReadEX(MemReadEX),
        .rtEX(rtEX),
        .intterupt(intterupt),
        .instructionID(instructionID),
        .PCplus4ID(PCplus4ID),
        .validID(validID),
        .stall(stall),
        .flushEX(flushEX),
        .intrTaken(intrTaken),
        .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idExp_t e;
        reset = 1'b1;
        instructionIF = 32'h0; PCplus4IF = 32'h0; PCSrcMEM = 1'b0;
        branchaddrMEM = 32'h0; MemReadEX = 1'b0; rtEX = 5'd0; intterupt = 1'b0;
        idQueue.push_back('{32'h0, 32'h0, 1'b0, 1'b1});
        tick(); tick();
        e = idQueue.pop_front();
        assertCount++;
        if (instructionID !== e.instr || PCplus4ID !== e.pc4 || validID !== e.valid) begin
            failCount++;
            $display("[TB] FAIL reset_id: got %h/%h/%b expected %h/%h/%b", instructionID, PCplus4ID, validID, e.instr, e.pc4, e.valid);
        end
        assertCount++;
        if (epc !== 32'h0 || intrTaken !== 1'b0 || stall !== 1'b0 || flushEX !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_outs: got epc=%h taken=%b stall=%b flush=%b expected all 0", epc, intrTaken, stall, flushEX);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] instrTab [4] = '{32'h8C080000, 32'h20010005, 32'h00221820, 32'hAC030008};
        idExp_t e;
        for (int i = 0; i < 4; i++) begin
            instructionIF = instrTab[i];
            PCplus4IF     = 32'(4 * (i + 1));
            idQueue.push_back('{instrTab[i], 32'(4 * (i + 1)), 1'b1, 1'b1});
            tick();
            e = idQueue.pop_front();
            assertCount++;
            if (instructionID !== e.instr || PCplus4ID !== e.pc4 || validID !== e.valid) begin
                failCount++;
                $display("[TB] FAIL fetch_%0d: got %h/%h/%b expected %h/%h/%b", i, instructionID, PCplus4ID, validID, e.instr, e.pc4, e.valid);
            end
        end
    endtask

    task automatic test_loaduse();
        idExp_t e;
        instructionIF = 32'h01095020; PCplus4IF = 32'h14;
        tick();
        MemReadEX = 1'b1; rtEX = 5'd8;
        instructionIF = 32'h8C090004; PCplus4IF = 32'h18;
        #1;
        assertCount++;
        if (stall !== LU_EN || flushEX !== LU_EN) begin
            failCount++;
            $display("[TB] FAIL loaduse_rs: got stall=%b flush=%b expected %b/%b", stall, flushEX, LU_EN, LU_EN);
        end
        if (LU_EN) idQueue.push_back('{32'h01095020, 32'h14, 1'b1, 1'b1});
        else       idQueue.push_back('{32'h8C090004, 32'h18, 1'b1, 1'b1});
        tick();
        MemReadEX = 1'b0;
        e = idQueue.pop_front();
        assertCount++;
        if (instructionID !== e.instr || PCplus4ID !== e.pc4 || validID !== e.valid) begin
            failCount++;
            $display("[TB] FAIL loaduse_hold: got %h/%h/%b expected %h/%h/%b", instructionID, PCplus4ID, validID, e.instr, e.pc4, e.valid);
        end
        #1;
        assertCount++;
        if (stall !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL loaduse_one_cycle: got stall=%b expected 0", stall);
        end
        idQueue.push_back('{32'h8C090004, 32'h18, 1'b1, 1'b1});
        tick();
        e = idQueue.pop_front();
        assertCount++;
        if (instructionID !== e.instr || PCplus4ID !== e.pc4 || validID !== e.valid) begin
            failCount++;
            $display("[TB] FAIL loaduse_resume: got %h/%h/%b expected %h/%h/%b", instructionID, PCplus4ID, validID, e.instr, e.pc4, e.valid);
        end
        // ID now holds rs=0, rt=9
        MemReadEX = 1'b1; rtEX = 5'd0;
        #1;
        assertCount++;
        if (stall !== 1'b0 || flushEX !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL loaduse_r0: got stall=%b flush=%b expected 0/0", stall, flushEX);
        end
        rtEX = 5'd9;
        #1;
        assertCount++;
        if (stall !== LU_EN || flushEX !== LU_EN) begin
            failCount++;
            $display("[TB] FAIL loaduse_rt: got stall=%b flush=%b expected %b/%b", stall, flushEX, LU_EN, LU_EN);
        end
        rtEX = 5'd10;
        #1;
        assertCount++;
        if (stall !== 1'b0 || flushEX !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL loaduse_nomatch: got stall=%b flush=%b expected 0/0", stall, flushEX);
        end
        MemReadEX = 1'b0;
    endtask

    task automatic test_branch();
        idExp_t e;
        MemReadEX = 1'b1; rtEX = 5'd9; PCSrcMEM = 1'b1; branchaddrMEM = 32'h200;
        instructionIF = 32'h12345678; PCplus4IF = 32'h1C;
        #1;
        assertCount++;
        if (stall !== 1'b0 || flushEX !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL branch_comb: got stall=%b flush=%b expected 0/1", stall, flushEX);
        end
        idQueue.push_back('{32'h0, 32'h0, 1'b0, 1'b0});
        tick();
        PCSrcMEM = 1'b0; MemReadEX = 1'b0;
        #1;
        e = idQueue.pop_front();
        assertCount++;
        if (instructionID !== e.instr || validID !== e.valid || flushEX !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL branch_flush: got %h/%b flush=%b expected %h/%b flush=0", instructionID, validID, flushEX, e.instr, e.valid);
        end
    endtask

    task automatic test_interrupt();
        idExp_t e;
        logic [31:0] expEpc;
        instructionIF = 32'h00000020; PCplus4IF = 32'h40;
        idQueue.push_back('{32'h00000020, 32'h40, 1'b1, 1'b1});
        tick();
        e = idQueue.pop_front();
        assertCount++;
        if (instructionID !== e.instr || PCplus4ID !== e.pc4 || validID !== e.valid) begin
            failCount++;
            $display("[TB] FAIL intr_setup: got %h/%h/%b expected %h/%h/%b", instructionID, PCplus4ID, validID, e.instr, e.pc4, e.valid);
        end
        intterupt = 1'b1; PCplus4IF = 32'h44;
        epcQueue.push_back(32'h3C);
        #1;
        assertCount++;
        if (stall !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL intr_edge_comb: got stall=%b expected 0", stall);
        end
        tick();
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            assertCount++;
            if (stall !== 1'b1 || flushEX !== 1'b1 || intrTaken !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL intr_drain_%0d: got stall=%b flush=%b taken=%b expected 1/1/0", i, stall, flushEX, intrTaken);
            end
            if (i == 0) intterupt = 1'b0;
            tick();
        end
        expEpc = epcQueue.pop_front();
        assertCount++;
        if (intrTaken !== 1'b1 || stall !== 1'b0 || epc !== expEpc) begin
            failCount++;
            $display("[TB] FAIL intr_take: got taken=%b stall=%b epc=%h expected 1/0/%h", intrTaken, stall, epc, expEpc);
        end
        tick();
        assertCount++;
        if (intrTaken !== 1'b0 || stall !== 1'b0 || flushEX !== 1'b0 || validID !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL intr_return: got taken=%b stall=%b flush=%b valid=%b expected 0/0/0/0", intrTaken, stall, flushEX, validID);
        end
    endtask

    task automatic test_epc_capture();
        logic [31:0] expEpc;
        // ID slot is empty, so the exception PC comes from fetch
        PCplus4IF = 32'h80; intterupt = 1'b1;
        epcQueue.push_back(32'h7C);
        tick();
        intterupt = 1'b0;
        for (int i = 0; i < DRAIN_CYCLES; i++) tick();
        expEpc = epcQueue.pop_front();
        assertCount++;
        if (intrTaken !== 1'b1 || epc !== expEpc) begin
            failCount++;
            $display("[TB] FAIL epc_invalid_id: got taken=%b epc=%h expected 1/%h", intrTaken, epc, expEpc);
        end
        tick();
        // PC+4 of zero in ID wraps the exception PC
        instructionIF = 32'h00000020; PCplus4IF = 32'h0;
        tick();
        intterupt = 1'b1; PCplus4IF = 32'h4;
        epcQueue.push_back(32'hFFFFFFFC);
        tick();
        intterupt = 1'b0;
        for (int i = 0; i < DRAIN_CYCLES; i++) tick();
        expEpc = epcQueue.pop_front();
        assertCount++;
        if (intrTaken !== 1'b1 || epc !== expEpc) begin
            failCount++;
            $display("[TB] FAIL epc_wrap: got taken=%b epc=%h expected 1/%h", intrTaken, epc, expEpc);
        end
        tick();
    endtask

    task automatic test_drain_branch();
        logic [31:0] expEpc;
        intterupt = 1'b1; PCplus4IF = 32'h50;
        tick();
        intterupt = 1'b0; PCSrcMEM = 1'b1; branchaddrMEM = 32'h100;
        epcQueue.push_back(32'h100);
        #1;
        assertCount++;
        if (stall !== 1'b1 || flushEX !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL drain_branch_comb: got stall=%b flush=%b expected 1/1", stall, flushEX);
        end
        tick();
        PCSrcMEM = 1'b0; intterupt = 1'b1;
        tick();
        intterupt = 1'b0;
        tick();
        expEpc = epcQueue.pop_front();
        assertCount++;
        if (intrTaken !== 1'b1 || epc !== expEpc) begin
            failCount++;
            $display("[TB] FAIL drain_branch_epc: got taken=%b epc=%h expected 1/%h", intrTaken, epc, expEpc);
        end
        PCplus4IF = 32'h300;
        epcQueue.push_back(32'h2FC);
        tick();
        assertCount++;
        if (intrTaken !== 1'b0 || stall !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL pending_run: got taken=%b stall=%b expected 0/0", intrTaken, stall);
        end
        tick();
        assertCount++;
        if (stall !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pending_entry: got stall=%b expected 1", stall);
        end
        for (int i = 0; i < DRAIN_CYCLES; i++) tick();
        expEpc = epcQueue.pop_front();
        assertCount++;
        if (intrTaken !== 1'b1 || epc !== expEpc) begin
            failCount++;
            $display("[TB] FAIL pending_take: got taken=%b epc=%h expected 1/%h", intrTaken, epc, expEpc);
        end
        tick();
    endtask

    task automatic test_branch_vs_intr_reset();
        PCSrcMEM = 1'b1; branchaddrMEM = 32'h400; intterupt = 1'b1;
        #1;
        assertCount++;
        if (flushEX !== 1'b1 || stall !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL branch_intr_comb: got flush=%b stall=%b expected 1/0", flushEX, stall);
        end
        tick();
        PCSrcMEM = 1'b0;
        #1;
        assertCount++;
        if (stall !== 1'b0 || intrTaken !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL branch_wins: got stall=%b taken=%b expected 0/0", stall, intrTaken);
        end
        tick();
        assertCount++;
        if (stall !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL deferred_entry: got stall=%b expected 1", stall);
        end
        intterupt = 1'b0;
        tick();
        intterupt = 1'b1;
        tick();
        assertCount++;
        if (stall !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL still_drain: got stall=%b expected 1", stall);
        end
        reset = 1'b1; intterupt = 1'b0;
        tick();
        assertCount++;
        if (stall !== 1'b0 || flushEX !== 1'b0 || intrTaken !== 1'b0 || epc !== 32'h0 ||
            instructionID !== 32'h0 || PCplus4ID !== 32'h0 || validID !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_mid_drain: got stall=%b flush=%b taken=%b epc=%h id=%h pc4=%h valid=%b expected all 0",
                     stall, flushEX, intrTaken, epc, instructionID, PCplus4ID, validID);
        end
        reset = 1'b0;
        for (int i = 0; i < DRAIN_CYCLES + 2; i++) begin
            tick();
            assertCount++;
            if (stall !== 1'b0 || intrTaken !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL pending_discarded_%0d: got stall=%b taken=%b expected 0/0", i, stall, intrTaken);
            end
        end
    endtask

    initial begin
        $display("[TB] ifid_stage bench start, load-use detection=%b", LU_EN);
        test_reset();
        test_fetch();
        test_loaduse();
        test_branch();
        test_interrupt();
        test_epc_capture();
        test_drain_branch();
        test_branch_vs_intr_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
